// File: rtl/stack_arb.sv
// rtl/stack_arb.sv - two-requester round-robin arbiter in front of a LIFO stack; optional grant lock via STACK_LOCK_EN
module stack_arb #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    REQ0_STB,
    input  logic                    REQ0_OP,
    input  logic [WIDTH-1:0]        REQ0_DAT,
    input  logic                    REQ0_LOCK,
    output logic                    REQ0_ACK,
    output logic [WIDTH-1:0]        REQ0_RDAT,
    output logic                    REQ0_ERR,
    input  logic                    REQ1_STB,
    input  logic                    REQ1_OP,
    input  logic [WIDTH-1:0]        REQ1_DAT,
    input  logic                    REQ1_LOCK,
    output logic                    REQ1_ACK,
    output logic [WIDTH-1:0]        REQ1_RDAT,
    output logic                    REQ1_ERR,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic [$clog2(DEPTH):0]  LEVEL
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] L_DEPTH = LW'(DEPTH);
    localparam logic [LW-1:0] L_ONE   = LW'(1);

    typedef enum logic [1:0] {
        S_ARB  = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_win;       // requester owning the op in flight
    logic                r_op;        // 1 = push, 0 = pop
    logic [WIDTH-1:0]    r_dat;
    logic                r_last;      // requester granted most recently
    logic [LW-1:0]       r_level;
    logic                r_full;
    logic                r_empty;
    logic                r_ack0;
    logic                r_ack1;
    logic                r_err0;
    logic                r_err1;
    logic [WIDTH-1:0]    r_rdat0;
    logic [WIDTH-1:0]    r_rdat1;
    logic [WIDTH-1:0]    r_mem [DEPTH];

`ifdef STACK_LOCK_EN
    logic                r_lock_vld;
    logic                r_lock_id;
    logic                w_lock;
`else
    logic                w_unused_lock;
    assign w_unused_lock = REQ0_LOCK ^ REQ1_LOCK;
`endif

    logic                w_any;
    logic                w_win;
    logic                w_op;
    logic [WIDTH-1:0]    w_dat;
    logic                w_wr;
    logic                w_err;
    logic [WIDTH-1:0]    w_rdat;
    logic [LW-1:0]       w_level_nxt;
    logic [AW-1:0]       w_top_idx;

    // index of the current top entry; wraps correctly when the stack is full
    assign w_top_idx = r_level[AW-1:0] - AW'(1);

    // pick a winner: round-robin between the two strobes, overridden by an active lock
    always_comb begin
        w_any = REQ0_STB | REQ1_STB;
        if (REQ0_STB && REQ1_STB) begin
            w_win = ~r_last;
        end else begin
            w_win = REQ1_STB;
        end
`ifdef STACK_LOCK_EN
        if (r_lock_vld) begin
            w_win = r_lock_id;
            w_any = r_lock_id ? REQ1_STB : REQ0_STB;
        end
        w_lock = w_win ? REQ1_LOCK : REQ0_LOCK;
`endif
        w_op  = w_win ? REQ1_OP  : REQ0_OP;
        w_dat = w_win ? REQ1_DAT : REQ0_DAT;
    end

    // outcome of the latched op against the current stack state
    always_comb begin
        w_wr        = 1'b0;
        w_err       = 1'b0;
        w_rdat      = '0;
        w_level_nxt = r_level;
        if (r_op) begin
            if (r_full) begin
                w_err = 1'b1;
            end else begin
                w_wr        = 1'b1;
                w_level_nxt = r_level + L_ONE;
            end
        end else begin
            if (r_empty) begin
                w_err = 1'b1;
            end else begin
                w_rdat      = r_mem[w_top_idx];
                w_level_nxt = r_level - L_ONE;
            end
        end
    end

    // storage write on commit; contents deliberately survive reset
    always_ff @(posedge CLK) begin
        if (!RST && (r_state == S_EXEC) && w_wr) begin
            r_mem[r_level[AW-1:0]] <= r_dat;
        end
    end

    // arbitration / execute / respond sequencer with registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_ARB;
            r_win     <= 1'b0;
            r_op      <= 1'b0;
            r_dat     <= '0;
            r_last    <= 1'b1;
            r_level   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_rdat0   <= '0;
            r_rdat1   <= '0;
`ifdef STACK_LOCK_EN
            r_lock_vld <= 1'b0;
            r_lock_id  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_ARB: begin
                    if (w_any) begin
                        r_state <= S_EXEC;
                        r_win   <= w_win;
                        r_op    <= w_op;
                        r_dat   <= w_dat;
                        r_last  <= w_win;
`ifdef STACK_LOCK_EN
                        r_lock_vld <= w_lock;
                        r_lock_id  <= w_win;
`endif
                    end
                end
                S_EXEC: begin
                    r_state <= S_RESP;
                    r_level <= w_level_nxt;
                    r_full  <= (w_level_nxt == L_DEPTH);
                    r_empty <= (w_level_nxt == '0);
                    if (r_win) begin
                        r_ack1  <= 1'b1;
                        r_err1  <= w_err;
                        r_rdat1 <= w_rdat;
                    end else begin
                        r_ack0  <= 1'b1;
                        r_err0  <= w_err;
                        r_rdat0 <= w_rdat;
                    end
                end
                S_RESP: begin
                    r_state <= S_ARB;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err0  <= 1'b0;
                    r_err1  <= 1'b0;
                    r_rdat0 <= '0;
                    r_rdat1 <= '0;
                end
                default: begin
                    r_state <= S_ARB;
                end
            endcase
        end
    end

    assign REQ0_ACK  = r_ack0;
    assign REQ0_ERR  = r_err0;
    assign REQ0_RDAT = r_rdat0;
    assign REQ1_ACK  = r_ack1;
    assign REQ1_ERR  = r_err1;
    assign REQ1_RDAT = r_rdat1;
    assign FULL      = r_full;
    assign EMPTY     = r_empty;
    assign LEVEL     = r_level;

endmodule

// File: doc/stack_arb.md
STACK_ARB -- requirements
Module: stack_arb

Interface
REQ-001 Parameter: DEPTH, default 16, number of stack entries (power of two, 2..256).
REQ-002 Parameter: WIDTH, default 8, entry width in bits (ASCII character).
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 REQ0_STB / REQ1_STB  input  1  requester request valid; held until that requester's ACK.
REQ-006 REQ0_OP / REQ1_OP  input  1  operation: 1 = push, 0 = pop.
REQ-007 REQ0_DAT / REQ1_DAT  input  WIDTH  push data.
REQ-008 REQ0_LOCK / REQ1_LOCK  input  1  keep grant after this op; used only under STACK_LOCK_EN.
REQ-009 REQ0_ACK / REQ1_ACK  output  1  one-cycle completion pulse.
REQ-010 REQ0_RDAT / REQ1_RDAT  output  WIDTH  pop result; valid while the same requester's ACK = 1.
REQ-011 REQ0_ERR / REQ1_ERR  output  1  op rejected (overflow/underflow); valid while the same requester's ACK = 1.
REQ-012 FULL, EMPTY  output  1  stack level == DEPTH, stack level == 0.
REQ-013 LEVEL  output  log2(DEPTH)+1  current entry count.

Function
REQ-014 Internal storage: DEPTH x WIDTH LIFO; one push or pop per granted request; all outputs registered.
REQ-015 FSM states ARB, EXEC, RESP; ARB -> EXEC when any STB = 1 at the edge, latching winner, OP and DAT; EXEC -> RESP unconditionally; RESP -> ARB unconditionally.
REQ-016 Latency: STB sampled in ARB at edge t -> op committed at edge t+1 -> winner ACK = 1 from t+1 to t+2; peak throughput one op per 3 cycles.
REQ-017 Arbitration: round-robin; single requester wins; if both request, the one not granted last wins; after reset requester 0 has priority.
REQ-018 Grant commits: STB, OP, DAT or LOCK changes after the ARB edge do not affect the current op.
REQ-019 Push, not full: write DAT at top, LEVEL+1, ERR = 0.
REQ-020 Push when FULL: storage and LEVEL unchanged, ERR = 1.
REQ-021 Pop, not empty: RDAT = top entry, LEVEL-1, ERR = 0.
REQ-022 Pop when EMPTY: RDAT = 0, LEVEL unchanged, ERR = 1.
REQ-023 Non-winner ACK, RDAT and ERR stay 0; RDAT and ERR of the winner return to 0 when its ACK drops.
REQ-024 FULL, EMPTY and LEVEL update on the same edge as the commit.

Reset
REQ-025 RST = 1 at any edge: state ARB, LEVEL = 0, EMPTY = 1, FULL = 0, all ACK/RDAT/ERR = 0, round-robin pointer to requester 0, lock cleared.
REQ-026 RST in EXEC or RESP aborts the op: no storage write is visible and no ACK pulse is emitted.
REQ-027 Storage contents are not cleared by RST; they are unreadable until rewritten because LEVEL = 0.

Configuration
REQ-028 Macro STACK_LOCK_EN defined: a winner with LOCK = 1 at the ARB edge becomes lock holder; ARB then grants only the holder; the other STB is ignored.
REQ-029 With STACK_LOCK_EN, the lock is released when the holder is granted with LOCK = 0; the round-robin pointer then updates normally.
REQ-030 Without STACK_LOCK_EN: LOCK inputs are present but ignored; pure round-robin.

Verification
REQ-031 Reset, req0 pushes 0x41 and 0x42, then pops twice -> RDAT 0x42 then 0x41, ERR = 0, LEVEL 2 -> 0, EMPTY = 1 at end.
REQ-032 Both STB high continuously, both push -> grants alternate 0,1,0,1, each ACK exactly 3 cycles apart, no double grant.
REQ-033 16 pushes then a 17th push -> ACK with ERR = 1, LEVEL = 16, FULL = 1; then pop on empty after 16 pops -> RDAT = 0, ERR = 1.
REQ-034 RST asserted in EXEC of a push of 0x2B -> no ACK, LEVEL = 0; a following pop -> ERR = 1.
REQ-035 STACK_LOCK_EN, req0 pushes with LOCK = 1 and req1 STB held high -> req0 next op (LOCK = 0) granted before req1; req1 is granted after.
REQ-036 Without STACK_LOCK_EN, same stimulus as REQ-035 -> req1 is granted immediately after req0's first op.
